uart_alu_if: RTL and testbench

//   Host-side peer of the uart block: drains received bytes from its RX FIFO port (rx_empty/rd_uart/r_data),

---
 rtl/uart_alu_if.sv | 134 +++++++++++++
 tb/tb_uart_alu_if.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if: pulls {A, B, OP} frames from the uart RX FIFO, drives the ALU and
// pushes the result byte into the uart TX FIFO. Optional frame timeout: UART_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_BIT         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  input  logic [DBIT-1:0]  alu_result,
  output logic             done_tick,
  output logic             timeout_tick
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND
  } state_t;

  state_t state, nxt;
  logic   expired;
  logic   tout;

`ifdef UART_IF_TIMEOUT_EN
  logic [TO_BIT-1:0] cnt;

  assign expired = (cnt == TO_BIT'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a frame is partially received
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (rd_uart || tout)
      cnt <= '0;
    else if (state == GET_B || state == GET_OP)
      cnt <= cnt + TO_BIT'(1);
    else
      cnt <= '0;
  end
`else
  logic [TO_BIT-1:0] unused_to;

  assign unused_to = TO_BIT'(TIMEOUT_CYCLES);
  assign expired   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= GET_A;
    else
      state <= nxt;
  end

  // Next state and Mealy handshake strobes; all quiet during reset
  always_comb begin
    nxt     = state;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    tout    = 1'b0;
    if (!reset) begin
      unique case (state)
        GET_A: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            nxt     = GET_B;
          end
        end
        GET_B: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            nxt     = GET_OP;
          end else if (expired) begin
            tout = 1'b1;
            nxt  = GET_A;
          end
        end
        GET_OP: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            nxt     = EXEC;
          end else if (expired) begin
            tout = 1'b1;
            nxt  = GET_A;
          end
        end
        EXEC: nxt = SEND;
        SEND: begin
          if (!tx_full) begin
            wr_uart = 1'b1;
            nxt     = GET_A;
          end
        end
        default: nxt = GET_A;
      endcase
    end
  end

  assign done_tick    = wr_uart;
  assign timeout_tick = tout;

  // Operand capture on each pop and result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      w_data <= '0;
    end else begin
      if (rd_uart && state == GET_A)
        alu_a <= r_data;
      if (rd_uart && state == GET_B)
        alu_b <= r_data;
      if (rd_uart && state == GET_OP)
        alu_op <= r_data[NB_OP-1:0];
      if (state == EXEC)
        w_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if: random and directed frames through FIFO and ALU models,
// checked against a frame-level reference model.
module tb_uart_alu_if;

  localparam int TMO = 16;
`ifdef UART_IF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int GAP   = 10;
  localparam int RGAP  = 20;
`else
  localparam bit TO_EN = 1'b0;
  localparam int GAP   = 50;
  localparam int RGAP  = 6;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       done_tick;
  logic       timeout_tick;

  int vec  = 0;
  int errs = 0;

  logic [7:0] rx_q[$];
  logic [7:0] fr[3];
  int         nb;
  int         ex;
  int         idle;
  int         pushes;
  int         touts;
  logic [7:0] last_push;
  bit         rnd_full;

  uart_alu_if #(
    .DBIT(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(TMO),
    .TO_BIT(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_empty(rx_empty),
    .r_data(r_data),
    .rd_uart(rd_uart),
    .tx_full(tx_full),
    .wr_uart(wr_uart),
    .w_data(w_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .done_tick(done_tick),
    .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'($urandom) : rx_q[0];
  endtask

  task automatic step();
    logic rd, wr, e_rd, e_wr, e_to;
    @(negedge clk);
    rd = rd_uart;
    wr = wr_uart;
    if (reset) begin
      chk("rst_rd", rd, 0);
      chk("rst_wr", wr, 0);
      chk("rst_done", done_tick, 0);
      chk("rst_to", timeout_tick, 0);
      nb   = 0;
      ex   = 0;
      idle = 0;
    end else begin
      if (nb == 3) ex++;
      e_rd = (nb < 3) && !rx_empty;
      e_wr = (nb == 3) && (ex >= 2) && !tx_full;
      e_to = 1'b0;
      if ((nb == 1 || nb == 2) && !e_rd) begin
        idle++;
        if (TO_EN && idle == TMO) e_to = 1'b1;
      end
      chk("rd", rd, e_rd);
      chk("wr", wr, e_wr);
      chk("done", done_tick, e_wr);
      chk("tout", timeout_tick, e_to);
      if (nb == 3 && ex >= 2)
        chk("w_data", w_data, alu_f(fr[0], fr[1], fr[2][5:0]));
      if (e_wr) begin
        chk("alu_a", alu_a, fr[0]);
        chk("alu_b", alu_b, fr[1]);
        chk("alu_op", alu_op, fr[2][5:0]);
        nb = 0;
        ex = 0;
      end else if (e_to) begin
        nb   = 0;
        idle = 0;
      end else if (e_rd) begin
        fr[nb] = rx_q[0];
        nb++;
        idle = 0;
        ex   = 0;
      end
      if (wr) begin
        pushes++;
        last_push = w_data;
      end
      if (timeout_tick) touts++;
    end
    @(posedge clk);
    #1;
    if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
    drive_rx();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_full) tx_full = ($urandom_range(0, 3) == 0);
      step();
    end
  endtask

  task automatic wait_push(input int p0, input int budget);
    int k;
    k = 0;
    while (pushes == p0 && k < budget) begin
      step();
      k++;
    end
    chk("push_seen", pushes - p0, 1);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
    drive_rx();
  endtask

  initial begin
    int p0, t0;
    logic [7:0] ops[6];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
    reset    = 1'b1;
    tx_full  = 1'b0;
    rnd_full = 1'b0;
    nb = 0; ex = 0; idle = 0; pushes = 0; touts = 0;
    last_push = '0;
    drive_rx();
    run(3);
    reset = 1'b0;
    run(1);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_w", w_data, 0);

    // 1: back-to-back frame, A+B
    p0 = pushes;
    send3(8'h05, 8'h03, 8'h20);
    wait_push(p0, 20);
    chk("t1_w", last_push, 8'h08);
    chk("t1_a", alu_a, 8'h05);
    chk("t1_b", alu_b, 8'h03);
    chk("t1_op", alu_op, 6'h20);
    run(3);
    chk("t1_once", pushes - p0, 1);

    // 2: spaced bytes, wrapping sum
    p0 = pushes;
    rx_q.push_back(8'h0F); drive_rx(); run(GAP);
    rx_q.push_back(8'hF1); drive_rx(); run(GAP);
    rx_q.push_back(8'h20); drive_rx();
    wait_push(p0, 20);
    chk("t2_w", last_push, 8'h00);

    // 3: TX full back-pressure at SEND
    p0 = pushes;
    send3(8'h11, 8'h22, 8'h20);
    run(3);
    tx_full = 1'b1;
    run(20);
    chk("t3_hold", pushes - p0, 0);
    chk("t3_wd", w_data, 8'h33);
    tx_full = 1'b0;
    wait_push(p0, 5);
    run(3);
    chk("t3_once", pushes - p0, 1);

    // 4: reset mid-frame
    p0 = pushes;
    rx_q.push_back(8'h11); drive_rx();
    run(1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("t4_a", alu_a, 0);
    send3(8'h02, 8'h02, 8'h20);
    wait_push(p0, 20);
    chk("t4_w", last_push, 8'h04);

    // 5: opcode upper bits discarded
    p0 = pushes;
    send3(8'h01, 8'h02, 8'hE3);
    wait_push(p0, 20);
    chk("t5_op", alu_op, 6'h23);

    // 6: lone byte then a fresh frame
    p0 = pushes;
    t0 = touts;
    rx_q.push_back(8'h01); drive_rx();
    run(TMO + 4);
    chk("t6_to", touts - t0, TO_EN ? 1 : 0);
    chk("t6_nowr", pushes - p0, 0);
    if (TO_EN) send3(8'h01, 8'h01, 8'h20);
    else begin
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h20);
      drive_rx();
    end
    wait_push(p0, 20);
    chk("t6_w", last_push, 8'h02);

    // random frames with random gaps and TX back-pressure
    rnd_full = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < 3; j++) begin
        run($urandom_range(0, RGAP));
        if (j < 2)
          rx_q.push_back(8'($urandom));
        else if ($urandom_range(0, 1) == 1)
          rx_q.push_back(ops[$urandom_range(0, 5)] | 8'($urandom_range(0, 3) << 6));
        else
          rx_q.push_back(8'($urandom));
        drive_rx();
      end
    end
    rnd_full = 1'b0;
    tx_full  = 1'b0;
    run(60);
    chk("drain_q", rx_q.size(), 0);
    chk("drain_wr", wr_uart, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
